ibus_sync_arb: RTL and testbench
================================

// Module: ibus_sync_arb
// PURPOSE
//  Arbitrates two core-side requesters (instruction fetch, load/store) onto the
//  single system-bus port, in the main (ungated) clock domain.
//  Uses the sync strobe from ibus_cksyn so every bus-side change lands on a
//  system-clock edge, and samples bus responses only on sync cycles.
//  Round-robin grant; one outstanding bus transfer at a time.
// PARAMETERS
//  AW      32  address width
//  DW      32  data width
//  TO_W     8  width of watchdog sync-pulse counter (timeout build only)
//  TO_LIM 200  sync pulses in WAIT before abort (timeout build only)
// PORTS
//  clk_ungated  in   1   main clock; sole clock
//  rst_a        in   1   reset, asynchronous, active-low
//  sync         in   1   1-cycle strobe: next edge is a system-clock edge
//  if_req       in   1   fetch request; hold with if_addr stable until if_gnt
//  if_addr      in   AW  fetch address
//  if_gnt       out  1   1-cycle pulse: fetch request issued to bus
//  if_done      out  1   1-cycle pulse: fetch complete, rdata valid
//  ls_req       in   1   load/store request; hold with addr/wr/wdata until ls_gnt
//  ls_addr      in   AW  load/store address
//  ls_wr        in   1   1 = write, 0 = read
//  ls_wdata     in   DW  write data
//  ls_gnt       out  1   1-cycle pulse: load/store issued to bus
//  ls_done      out  1   1-cycle pulse: load/store complete
//  rdata        out  DW  read data, valid in the done cycle, held until next done
//  xfer_err     out  1   qualifies done: 1 = transfer aborted by watchdog
//  bus_req      out  1   system-bus request, registered, changes only on sync
//  bus_addr     out  AW  registered, stable while bus_req=1
//  bus_wr       out  1   registered, stable while bus_req=1
//  bus_wdata    out  DW  registered, stable while bus_req=1
//  bus_ack      in   1   bus accept+complete; sampled only when sync=1
//  bus_rdata    in   DW  sampled with bus_ack
// BEHAVIOUR
//  - Reset: state=IDLE, bus_req/bus_wr=0, bus_addr/bus_wdata/rdata=0, all
//    gnt/done/xfer_err=0, last_owner=LS (fetch wins first tie), wdog=0.
//  - Async reset mid-transfer: bus_req drops immediately; no done issued.
//  - FSM IDLE: if sync=1 and (if_req|ls_req): pick winner; only one pending ->
//    it wins; both -> the one not equal to last_owner. Registered same edge:
//    bus_req=1, bus_addr/wr/wdata from winner (fetch: bus_wr=0, wdata=0),
//    winner gnt pulse, last_owner=winner, -> WAIT. Requests with sync=0 wait.
//  - Request arriving in the same cycle as sync is eligible that cycle.
//  - WAIT: when sync=1 and bus_ack=1: rdata<=bus_rdata (reads only; writes
//    keep rdata), owner done pulse, bus_req<=0, -> IDLE. bus_ack with sync=0
//    is ignored.
//  - New issue no earlier than the next sync after return to IDLE (one idle
//    system cycle between transfers). Requests during WAIT are held pending.
//  - sync held high continuously (1:1 ratio) is legal: issue/complete every cycle
//    sync is set.
//  - gnt and done never pulse together for the same requester; at most one
//    done per cycle.
// CONFIGURATION
//  IBUS_ARB_TIMEOUT_EN defined: wdog counts sync pulses in WAIT (clears on
//   entry); when wdog reaches TO_LIM without ack: bus_req<=0, owner done pulse
//   with xfer_err=1, rdata unchanged, -> IDLE. Ack on the limit cycle wins
//   (normal completion, xfer_err=0).
//  Not defined: no counter; WAIT lasts until ack; xfer_err tied 0.
// TESTING
//  1. Fetch only, sync every 3rd cycle, if_req @addr 0x100, ack on 2nd sync
//     -> if_gnt on 1st sync, bus_req 1 for 2 sync periods, if_done+rdata.
//  2. if_req and ls_req together after reset -> fetch first, load/store next
//     sync after IDLE; repeat both -> grants alternate IF,LS,IF,LS.
//  3. ls write 0xDEADBEEF @0x40, bus_ack pulsed with sync=0 -> ignored; ack
//     on sync -> ls_done, rdata unchanged, bus_wr/bus_wdata stable throughout.
//  4. rst_a low while WAIT -> bus_req 0 same cycle, no done; after release
//     pending if_req re-issued on first sync.
//  5. TIMEOUT_EN, TO_LIM=4, never ack -> ls_done+xfer_err=1 at 4th sync in
//     WAIT; variant ack on 4th sync -> xfer_err=0.
//  6. sync tied 1, alternating requests -> transfer every 2 cycles, no loss.

Source files
------------

// File: rtl/ibus_sync_arb.sv
// ibus_sync_arb: round-robin arbiter of fetch and load/store onto one system-bus port.
// Bus-side outputs change only on sync cycles; bus responses are sampled only when sync=1.
// Optional watchdog abort of a stalled transfer: define IBUS_ARB_TIMEOUT_EN.
module ibus_sync_arb #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_W   = 8,
  parameter int unsigned TO_LIM = 200
) (
  input  logic          clk_ungated,
  input  logic          rst_a,
  input  logic          sync,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  input  logic          ls_req,
  input  logic [AW-1:0] ls_addr,
  input  logic          ls_wr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_done,
  output logic [DW-1:0] rdata,
  output logic          xfer_err,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  output logic          bus_wr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic          last_ls_q, last_ls_d;    // owner of the current/last transfer (1 = LS)
  logic          bus_req_q, bus_req_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic          bus_wr_q, bus_wr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic          if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic          win_ls_c;
  logic          finish_c;

`ifdef IBUS_ARB_TIMEOUT_EN
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;
`else
  logic            unused_to_cfg;
  assign unused_to_cfg = (TO_W == 0) ^ (TO_LIM == 0);
`endif

  // Load/store wins if alone, or on a tie when fetch owned the last transfer
  assign win_ls_c = ls_req & (~if_req | ~last_ls_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wr_d    = bus_wr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    finish_c    = 1'b0;
`ifdef IBUS_ARB_TIMEOUT_EN
    wdog_d      = wdog_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (sync && (if_req || ls_req)) begin
          state_d   = S_WAIT;
          bus_req_d = 1'b1;
          last_ls_d = win_ls_c;
`ifdef IBUS_ARB_TIMEOUT_EN
          wdog_d    = '0;
`endif
          if (win_ls_c) begin
            bus_addr_d  = ls_addr;
            bus_wr_d    = ls_wr;
            bus_wdata_d = ls_wdata;
            ls_gnt_d    = 1'b1;
          end else begin
            bus_addr_d  = if_addr;
            bus_wr_d    = 1'b0;
            bus_wdata_d = '0;
            if_gnt_d    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (sync) begin
          if (bus_ack) begin
            finish_c = 1'b1;
            if (!bus_wr_q) rdata_d = bus_rdata;
          end
`ifdef IBUS_ARB_TIMEOUT_EN
          else if (wdog_q == TO_W'(TO_LIM - 1)) begin
            finish_c = 1'b1;
            err_d    = 1'b1;
          end else begin
            wdog_d = wdog_q + TO_W'(1);
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (finish_c) begin
      state_d   = S_IDLE;
      bus_req_d = 1'b0;
      if_done_d = ~last_ls_q;
      ls_done_d = last_ls_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk_ungated or negedge rst_a) begin
    if (!rst_a) begin
      state_q     <= S_IDLE;
      last_ls_q   <= 1'b1;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wr_q    <= 1'b0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wr_q    <= bus_wr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
    end
  end

`ifdef IBUS_ARB_TIMEOUT_EN
  // Watchdog counter and abort flag
  always_ff @(posedge clk_ungated or negedge rst_a) begin
    if (!rst_a) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign xfer_err = err_q;
`else
  assign xfer_err = 1'b0;
`endif

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wr    = bus_wr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_ibus_sync_arb.sv
// Testbench for ibus_sync_arb: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_ibus_sync_arb;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO_W = 8;
  localparam int unsigned TO_LIM = 4;

  logic clk = 1'b0;
  logic rst_a, sync, if_req, ls_req, ls_wr, bus_ack;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, bus_rdata;
  logic if_gnt, if_done, ls_gnt, ls_done, xfer_err, bus_req, bus_wr;
  logic [DW-1:0] rdata, bus_wdata;
  logic [AW-1:0] bus_addr;

  ibus_sync_arb #(.AW(AW), .DW(DW), .TO_W(TO_W), .TO_LIM(TO_LIM)) dut (
    .clk_ungated(clk), .rst_a(rst_a), .sync(sync),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_wr(ls_wr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .rdata(rdata), .xfer_err(xfer_err),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  int n_done = 0;
  int glog[$];

  // Reference model: one outstanding transfer, its owner and its attributes
  bit          m_busy, m_last_ls, m_wr, m_ig, m_lg, m_id, m_ld, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int          m_syncs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_last_ls = 1; m_wr = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_ig = 0; m_lg = 0; m_id = 0; m_ld = 0; m_err = 0; m_syncs = 0;
  endtask

  task automatic model_finish(input bit err);
    m_busy = 0;
    m_err = err;
    if (m_last_ls) m_ld = 1; else m_id = 1;
  endtask

  // Predict the effect of the coming clock edge from the current inputs
  task automatic model_edge();
    bit win_ls;
    m_ig = 0; m_lg = 0; m_id = 0; m_ld = 0; m_err = 0;
    if (!rst_a) begin
      model_reset();
    end else if (!m_busy) begin
      if (sync && (if_req || ls_req)) begin
        win_ls = (if_req && ls_req) ? !m_last_ls : ls_req;
        m_busy = 1; m_last_ls = win_ls; m_syncs = 0;
        m_addr  = win_ls ? ls_addr : if_addr;
        m_wr    = win_ls ? ls_wr : 1'b0;
        m_wdata = win_ls ? ls_wdata : '0;
        if (win_ls) m_lg = 1; else m_ig = 1;
      end
    end else if (sync) begin
      m_syncs++;
      if (bus_ack) begin
        if (!m_wr) m_rdata = bus_rdata;
        model_finish(0);
      end
`ifdef IBUS_ARB_TIMEOUT_EN
      else if (m_syncs == TO_LIM) model_finish(1);
`endif
    end
  endtask

  task automatic check_all();
    check("ctl", 32'({bus_req, bus_wr, if_gnt, ls_gnt, if_done, ls_done, xfer_err}),
                 32'({m_busy, m_wr, m_ig, m_lg, m_id, m_ld, m_err}));
    check("bus_addr", bus_addr, m_addr);
    check("bus_wdata", bus_wdata, m_wdata);
    check("rdata", rdata, m_rdata);
  endtask

  // One clock: predict, advance, compare; requesters drop their request on grant
  task automatic cyc();
    model_edge();
    @(posedge clk); #1;
    cyc_no++;
    check_all();
    if (if_gnt) begin if_req = 0; glog.push_back(0); end
    if (ls_gnt) begin ls_req = 0; glog.push_back(1); end
    n_done += int'(if_done) + int'(ls_done);
  endtask

  task automatic one(input bit s, input bit a);
    sync = s; bus_ack = a;
    cyc();
  endtask

  // sdiv: 0 random sync, else sync every sdiv cycles; amode: 0 none, 1 on sync, 2 random
  task automatic cycles(input int n, input int sdiv, input int amode, input int rpct);
    for (int i = 0; i < n; i++) begin
      sync = (sdiv == 0) ? 1'($urandom_range(0, 1)) : ((cyc_no % sdiv) == 0);
      case (amode)
        0: bus_ack = 1'b0;
        1: bus_ack = sync;
        default: bus_ack = 1'($urandom_range(0, 1));
      endcase
      bus_rdata = $urandom;
      cyc();
      if (!if_req && $urandom_range(0, 99) < rpct) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!ls_req && $urandom_range(0, 99) < rpct) begin
        ls_req = 1; ls_addr = $urandom; ls_wr = 1'($urandom_range(0, 1)); ls_wdata = $urandom;
      end
    end
  endtask

  // Asynchronous reset between edges, checked before the next edge
  task automatic reset_pulse();
    #2;
    rst_a = 0;
    #1;
    model_reset();
    check_all();
    sync = 0; bus_ack = 0;
    cyc();
    cyc();
    rst_a = 1;
  endtask

  logic [DW-1:0] saved;

  initial begin
    rst_a = 1; sync = 0; bus_ack = 0; if_req = 0; ls_req = 0; ls_wr = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; bus_rdata = '0;
    model_reset();
    #1 rst_a = 0;
    #1 check_all();
    cyc(); cyc();
    rst_a = 1;

    // Fetch only, sync every 3rd cycle, ack on the 2nd sync in WAIT
    if_req = 1; if_addr = 32'h100; bus_rdata = 32'hCAFE_0001;
    one(0, 0); one(0, 0); one(1, 0);
    check("t1_gnt", 32'(if_gnt), 32'd1);
    check("t1_addr", bus_addr, 32'h100);
    one(0, 0); one(0, 0); one(1, 0);
    one(0, 0); one(0, 1); one(1, 1);
    check("t1_done", 32'(if_done), 32'd1);
    check("t1_rdata", rdata, 32'hCAFE_0001);
    one(0, 0);

    // Both requesting after reset: fetch first, then strict alternation
    reset_pulse();
    glog.delete();
    if_req = 1; if_addr = 32'h200; ls_req = 1; ls_addr = 32'h300; ls_wr = 0; ls_wdata = '0;
    cycles(40, 2, 1, 100);
    if_req = 0; ls_req = 0;
    cycles(6, 2, 1, 0);
    check("t2_ngnt", 32'(glog.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < glog.size(); i++) check("t2_alt", 32'(glog[i]), 32'(i % 2));

    // Write: ack without sync ignored, rdata untouched, bus fields stable
    saved = m_rdata;
    ls_req = 1; ls_addr = 32'h40; ls_wr = 1; ls_wdata = 32'hDEAD_BEEF; bus_rdata = 32'h1234_5678;
    one(0, 0); one(1, 0);
    check("t3_gnt", 32'(ls_gnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      one(0, 1);
      check("t3_wr", 32'({bus_req, bus_wr}), 32'b11);
      check("t3_wdata", bus_wdata, 32'hDEAD_BEEF);
      check("t3_addr", bus_addr, 32'h40);
    end
    one(1, 1);
    check("t3_done", 32'({ls_done, bus_req}), 32'b10);
    check("t3_rdata", rdata, saved);
    one(0, 0);

    // sync tied high, both always requesting: one transfer per two cycles
    one(0, 0);
    if_req = 1; ls_req = 1; ls_wr = 0;
    n_done = 0;
    cycles(40, 1, 1, 100);
    check("t6_done", 32'(n_done), 32'd20);
    if_req = 0; ls_req = 0;
    cycles(4, 2, 1, 0);

    // Reset during WAIT with a fetch pending; re-issued on first sync after release
    if_req = 1; if_addr = 32'h500;
    one(0, 0); one(1, 0);
    check("t4_gnt", 32'(if_gnt), 32'd1);
    if_req = 1; if_addr = 32'h504;
    one(0, 0);
    n_done = 0;
    reset_pulse();
    check("t4_nodone", 32'(n_done), 32'd0);
    one(0, 0); one(1, 0);
    check("t4_regnt", 32'({if_gnt, bus_req}), 32'b11);
    check("t4_addr", bus_addr, 32'h504);
    one(0, 0); one(1, 1); one(0, 0);

`ifdef IBUS_ARB_TIMEOUT_EN
    // Watchdog: abort at the TO_LIM-th sync in WAIT; an ack on that sync wins
    ls_req = 1; ls_addr = 32'h80; ls_wr = 0;
    one(1, 0);
    for (int i = 0; i < 3; i++) begin one(0, 0); one(1, 0); end
    check("t5_wait", 32'({bus_req, ls_done}), 32'b10);
    one(0, 0); one(1, 0);
    check("t5_abort", 32'({ls_done, xfer_err, bus_req}), 32'b110);
    ls_req = 1;
    one(0, 0); one(1, 0);
    for (int i = 0; i < 3; i++) begin one(0, 0); one(1, 0); end
    bus_rdata = 32'h0BAD_F00D;
    one(0, 0); one(1, 1);
    check("t5_ackwin", 32'({ls_done, xfer_err}), 32'b10);
    check("t5_rdata", rdata, 32'h0BAD_F00D);
    one(0, 0);
`endif

    // Randomized traffic: random sync, random acks (also off-sync), random requests
    cycles(400, 0, 2, 40);
    cycles(200, 1, 2, 60);
    cycles(40, 2, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
